// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared defaults and sizing helpers for the slow-domain synchronous FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_W          = 8;
    localparam int DEFAULT_DEPTH           = 16;
    localparam int DEFAULT_ALMOST_EMPTY_TH = 2;
    localparam int ALMOST_FULL_MARGIN      = 2;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int addr_w_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int almost_full_th_of(input int depth);
        return depth - ALMOST_FULL_MARGIN;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bundle of the FIFO; master is the user side, slave the FIFO.
interface sync_fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
);
    localparam int ADDR_W = addr_w_of(DEPTH);

    logic              wr_req;
    logic [DATA_W-1:0] data_in;
    logic              rd_req;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_req, data_in, rd_req,
        input  data_out, data_out_valid, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_req, data_in, rd_req,
        output data_out, data_out_valid, full, empty, almost_full,
               almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ctrl_edge_pulse.sv
// One-bit rising-edge detector; with BYPASS set the raw level passes straight through.
module edge_pulse #(
    parameter bit BYPASS = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic req_i,
    output logic pulse_o
);

    logic req_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_i;
        end
    end

    // A request already high as reset releases still yields one pulse, since req_q was cleared.
    assign pulse_o = BYPASS ? req_i : (req_i & ~req_q);

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO for the divided-clock domain with optional push/pop edge qualification.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W          = DEFAULT_DATA_W,
    parameter int DEPTH           = DEFAULT_DEPTH,
    parameter int ALMOST_FULL_TH  = almost_full_th_of(DEPTH),
    parameter int ALMOST_EMPTY_TH = DEFAULT_ALMOST_EMPTY_TH,
    parameter bit EDGE_MODE       = 1'b1
) (
    input  logic            clock_in,
    input  logic            reset,
    sync_fifo_ctrl_if.slave bus
);

    localparam int ADDR_W = addr_w_of(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_TH    = (ADDR_W + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_W:0] AE_TH    = (ADDR_W + 1)'(ALMOST_EMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_out_q;
    logic              data_out_valid_q;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic wr_pulse, rd_pulse;
    logic wr_ok, rd_ok;
    logic empty_w, full_w;

    edge_pulse #(.BYPASS(EDGE_MODE == 1'b0)) u_wr_edge (
        .clk     (clock_in),
        .srst    (reset),
        .req_i   (bus.wr_req),
        .pulse_o (wr_pulse)
    );

    edge_pulse #(.BYPASS(EDGE_MODE == 1'b0)) u_rd_edge (
        .clk     (clock_in),
        .srst    (reset),
        .req_i   (bus.rd_req),
        .pulse_o (rd_pulse)
    );

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_ok = rd_pulse & ~empty_w;
    assign wr_ok = wr_pulse & (~full_w | rd_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  | (wr_pulse & ~wr_ok);
        underflow_d = underflow_q | (rd_pulse & ~rd_ok);
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clock_in) begin
        if (wr_ok && !reset) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            overflow_q       <= 1'b0;
            underflow_q      <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            data_out_valid_q <= rd_ok;
            overflow_q       <= overflow_d;
            underflow_q      <= underflow_d;
            if (rd_ok) begin
                data_out_q <= mem[rd_ptr_q];
            end
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;
    assign bus.count          = count_q;
    assign bus.full           = full_w;
    assign bus.empty          = empty_w;
    assign bus.almost_full    = (count_q >= AF_TH);
    assign bus.almost_empty   = (count_q <= AE_TH);
    assign bus.overflow       = overflow_q;
    assign bus.underflow      = underflow_q;

endmodule
